// File: rtl/mem_arbiter_pkg.sv
// Shared constants, owner encoding and response-pipe entry type for the memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned RegWidth  = 32;
    localparam int unsigned InstWidth = 32;
    localparam logic [RegWidth-1:0] PcRst = 32'h8000_0000;

    // Which requester a pipe entry belongs to
    typedef enum logic {
        MemOwnIfu = 1'b0,
        MemOwnLsu = 1'b1
    } memOwner_e;

    // One in-flight access travelling through the response pipe
    typedef struct packed {
        logic      valid;
        memOwner_e owner;
        logic      err;
        logic      isStore;
    } pipeEntry_t;

    // True when the byte address maps onto a word of a 2**idxWidth-word memory
    function automatic logic addrInRange(input logic [RegWidth-1:0] addr,
                                         input int unsigned        idxWidth);
        logic [RegWidth-1:0] offset;
        offset = addr - PcRst;
        return (addr >= PcRst) && ((offset >> (idxWidth + 2)) == '0);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency shift register tracking in-flight memory accesses, with IFU kill.
module mem_resp_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  pipeEntry_t pushEntry,
    input  logic       killIfu,
    output pipeEntry_t headEntry
);

    pipeEntry_t stages [MEM_LAT];

    // Drop an IFU entry when a fetch redirect is active
    function automatic pipeEntry_t applyKill(input pipeEntry_t entry, input logic kill);
        pipeEntry_t result;
        result = entry;
        if (kill && (entry.owner == MemOwnIfu)) begin
            result.valid = 1'b0;
        end
        return result;
    endfunction

    // Advance entries one stage per cycle, scrubbing IFU entries on kill
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= pushEntry;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                stages[i] <= applyKill(stages[i-1], killIfu);
            end
        end
    end

    // Head is killed in the same cycle as the redirect and hidden during reset
    always_comb begin
        headEntry = applyKill(stages[MEM_LAT-1], killIfu);
        if (rst) begin
            headEntry.valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch and load/store.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW        = 8,
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned LS_STREAK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [RegWidth-1:0]  ifu_addr,
    input  logic                 ifu_flush,
    output logic                 ifu_resp_valid,
    output logic [InstWidth-1:0] ifu_resp_data,
    output logic                 ifu_resp_err,

    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic [RegWidth-1:0]  lsu_addr,
    input  logic                 lsu_wen,
    input  logic [RegWidth-1:0]  lsu_wdata,
    input  logic [3:0]           lsu_wmask,
    output logic                 lsu_resp_valid,
    output logic [RegWidth-1:0]  lsu_resp_data,
    output logic                 lsu_resp_err,

    output logic                 mem_en,
    output logic                 mem_wen,
    output logic [MEM_AW-1:0]    mem_idx,
    output logic [RegWidth-1:0]  mem_wdata,
    output logic [3:0]           mem_wmask,
    input  logic [RegWidth-1:0]  mem_rdata
);

    localparam int unsigned StreakWidth = $clog2(LS_STREAK_MAX + 1);

    logic [StreakWidth-1:0] streak;
    logic                   ifuEligible;
    logic                   lsuPriority;
    logic                   ifuGrant;
    logic                   lsuGrant;
    logic                   ifuInRange;
    logic                   lsuInRange;
    logic [RegWidth-1:0]    respData;
    pipeEntry_t             pushEntry;
    pipeEntry_t             headEntry;

    // Address range decode for both requesters
    always_comb begin
        ifuInRange = addrInRange(ifu_addr, MEM_AW);
        lsuInRange = addrInRange(lsu_addr, MEM_AW);
    end

    // One grant per cycle: LSU first until its streak is used up, then a waiting IFU
    always_comb begin
        ifuEligible = ifu_req_valid && !ifu_flush;
        lsuPriority = streak < StreakWidth'(LS_STREAK_MAX);
        lsuGrant    = !rst && lsu_req_valid && (lsuPriority || !ifuEligible);
        ifuGrant    = !rst && !lsuGrant && ifuEligible;
    end

    assign ifu_req_ready = ifuGrant;
    assign lsu_req_ready = lsuGrant;

    // Count LSU grants taken while the IFU waits; any IFU grant or idle IFU resets it
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (!ifu_req_valid || ifuGrant) begin
            streak <= '0;
        end else if (lsuGrant && lsuPriority) begin
            streak <= streak + StreakWidth'(1);
        end
    end

    // Drive the memory port only for granted, in-range accesses
    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (lsuGrant && lsuInRange) begin
            mem_en    = 1'b1;
            mem_wen   = lsu_wen;
            mem_idx   = MEM_AW'((lsu_addr - PcRst) >> 2);
            mem_wdata = lsu_wdata;
            mem_wmask = lsu_wmask;
        end else if (ifuGrant && ifuInRange) begin
            mem_en    = 1'b1;
            mem_idx   = MEM_AW'((ifu_addr - PcRst) >> 2);
        end
    end

    // Every grant, including out-of-range ones, enters the response pipe
    always_comb begin
        pushEntry = '0;
        if (lsuGrant) begin
            pushEntry.valid   = 1'b1;
            pushEntry.owner   = MemOwnLsu;
            pushEntry.err     = !lsuInRange;
            pushEntry.isStore = lsu_wen;
        end else if (ifuGrant) begin
            pushEntry.valid   = 1'b1;
            pushEntry.owner   = MemOwnIfu;
            pushEntry.err     = !ifuInRange;
        end
    end

    mem_resp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .pushEntry (pushEntry),
        .killIfu   (ifu_flush),
        .headEntry (headEntry)
    );

    // Route the head of the pipe to its owner; errors and stores carry no data
    always_comb begin
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        lsu_resp_err   = 1'b0;
        respData       = (headEntry.err || headEntry.isStore) ? '0 : mem_rdata;
        if (headEntry.valid) begin
            if (headEntry.owner == MemOwnLsu) begin
                lsu_resp_valid = 1'b1;
                lsu_resp_data  = respData;
                lsu_resp_err   = headEntry.err;
            end else begin
                ifu_resp_valid = 1'b1;
                ifu_resp_data  = InstWidth'(respData);
                ifu_resp_err   = headEntry.err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter at memory latencies 1 and 3.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned Words     = 256;
    localparam int          StreakMax = 4;
    localparam int          NCyc      = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifuReqValid, ifuFlush, lsuReqValid, lsuWen, loadMem;
    logic [31:0] ifuAddr, lsuAddr, lsuWdata;
    logic [3:0]  lsuWmask;

    logic        ifuReady [2], ifuRespValid [2], ifuRespErr [2];
    logic        lsuReady [2], lsuRespValid [2], lsuRespErr [2];
    logic        memEn [2], memWen [2];
    logic [31:0] ifuRespData [2], lsuRespData [2], memWdata [2], memRdata [2];
    logic [7:0]  memIdx [2];
    logic [3:0]  memWmask [2];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(8), .MEM_LAT(1), .LS_STREAK_MAX(4)) dutLat1 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifuReqValid), .ifu_req_ready(ifuReady[0]), .ifu_addr(ifuAddr),
        .ifu_flush(ifuFlush), .ifu_resp_valid(ifuRespValid[0]), .ifu_resp_data(ifuRespData[0]),
        .ifu_resp_err(ifuRespErr[0]),
        .lsu_req_valid(lsuReqValid), .lsu_req_ready(lsuReady[0]), .lsu_addr(lsuAddr),
        .lsu_wen(lsuWen), .lsu_wdata(lsuWdata), .lsu_wmask(lsuWmask),
        .lsu_resp_valid(lsuRespValid[0]), .lsu_resp_data(lsuRespData[0]), .lsu_resp_err(lsuRespErr[0]),
        .mem_en(memEn[0]), .mem_wen(memWen[0]), .mem_idx(memIdx[0]), .mem_wdata(memWdata[0]),
        .mem_wmask(memWmask[0]), .mem_rdata(memRdata[0])
    );

    mem_arbiter #(.MEM_AW(8), .MEM_LAT(3), .LS_STREAK_MAX(4)) dutLat3 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifuReqValid), .ifu_req_ready(ifuReady[1]), .ifu_addr(ifuAddr),
        .ifu_flush(ifuFlush), .ifu_resp_valid(ifuRespValid[1]), .ifu_resp_data(ifuRespData[1]),
        .ifu_resp_err(ifuRespErr[1]),
        .lsu_req_valid(lsuReqValid), .lsu_req_ready(lsuReady[1]), .lsu_addr(lsuAddr),
        .lsu_wen(lsuWen), .lsu_wdata(lsuWdata), .lsu_wmask(lsuWmask),
        .lsu_resp_valid(lsuRespValid[1]), .lsu_resp_data(lsuRespData[1]), .lsu_resp_err(lsuRespErr[1]),
        .mem_en(memEn[1]), .mem_wen(memWen[1]), .mem_idx(memIdx[1]), .mem_wdata(memWdata[1]),
        .mem_wmask(memWmask[1]), .mem_rdata(memRdata[1])
    );

    // Memory arrays behind each DUT: byte-masked writes, reads returned after 1 / 3 cycles
    logic [31:0] initWord [Words];
    logic [31:0] phys [2][Words];
    logic [31:0] rdPipe [2][3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (loadMem) begin
                for (int k = 0; k < int'(Words); k++) phys[i][k] <= initWord[k];
            end else if (memEn[i] && memWen[i]) begin
                for (int b = 0; b < 4; b++)
                    if (memWmask[i][b]) phys[i][memIdx[i]][8*b +: 8] <= memWdata[i][8*b +: 8];
            end
            rdPipe[i][0] <= memEn[i] ? phys[i][memIdx[i]] : 32'h5A5A_A5A5;
            rdPipe[i][1] <= rdPipe[i][0];
            rdPipe[i][2] <= rdPipe[i][1];
        end
    end

    assign memRdata[0] = rdPipe[0][0];
    assign memRdata[1] = rdPipe[1][2];

    // Reference model: per-cycle grant log, redirect/reset history and a memory image
    bit          gValid [NCyc], gLsu [NCyc], gErr [NCyc], flushLog [NCyc], rstLog [NCyc];
    logic [31:0] gData [NCyc];
    logic [31:0] refMem [Words];
    int          cyc, streak, vectors, miscompares;
    bit          dummyI, dummyL;

    logic        lastIfuReady [2], lastLsuReady [2], lastMemEn [2];
    logic        lastIfuRespValid [2], lastLsuRespValid [2], lastLsuRespErr [2];
    logic [31:0] lastIfuRespData [2], lastLsuRespData [2];
    logic [7:0]  lastMemIdx [2];

    function automatic longint byteOffset(input logic [31:0] a);
        return longint'({32'd0, a}) - longint'({32'd0, PcRst});
    endfunction

    function automatic bit modelInRange(input logic [31:0] a);
        longint off = byteOffset(a);
        return (off >= 0) && ((off / 4) < longint'(Words));
    endfunction

    // What a DUT with latency lat should be returning in cycle c
    function automatic void expResp(input int lat, input int c, output bit v, output bit isLsu,
                                    output bit e, output logic [31:0] d);
        int g = c - lat;
        v = 0; isLsu = 0; e = 0; d = '0;
        if (g < 0) return;
        if (!gValid[g]) return;
        for (int k = g + 1; k <= c; k++) begin
            if (rstLog[k]) return;
            if (!gLsu[g] && flushLog[k]) return;
        end
        v = 1; isLsu = gLsu[g]; e = gErr[g]; d = gData[g];
    endfunction

    function automatic logic [31:0] randAddr();
        int s = int'($urandom_range(0, 19));
        if (s == 0) return PcRst - 32'(4 * $urandom_range(1, 4));
        if (s == 1) return PcRst + 32'd1024 + 32'($urandom_range(0, 64));
        if (s == 2) return 32'($urandom);
        return PcRst + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
    endfunction

    // Apply one cycle of stimulus, predict, and compare both DUTs before the next edge
    task automatic step(input bit iv, input logic [31:0] ia, input bit fl, input bit lv,
                        input logic [31:0] la, input bit w, input logic [31:0] wd,
                        input logic [3:0] wm, input bit r, output bit ifuGot, output bit lsuGot);
        bit ifuOk, lsuWin, ifuWin, ok, expEn, ev, eLsu, eErr;
        bit eIfuV, eLsuV, eIfuErr, eLsuErr;
        logic [31:0] acc, eData, eIfuData, eLsuData;
        int idx, lat;
        if (cyc >= NCyc) begin
            $display("FAIL cycle budget: cyc %0d exceeds %0d", cyc, NCyc);
            $fatal(1);
        end
        rst = r; ifuReqValid = iv; ifuAddr = ia; ifuFlush = fl;
        lsuReqValid = lv; lsuAddr = la; lsuWen = w; lsuWdata = wd; lsuWmask = wm;
        ifuOk  = iv && !fl;
        lsuWin = !r && lv && ((streak < StreakMax) || !ifuOk);
        ifuWin = !r && !lsuWin && ifuOk;
        acc    = lsuWin ? la : ia;
        ok     = modelInRange(acc);
        idx    = ok ? int'(byteOffset(acc) / 4) : 0;
        expEn  = (lsuWin || ifuWin) && ok;
        gValid[cyc]   = lsuWin || ifuWin;
        gLsu[cyc]     = lsuWin;
        gErr[cyc]     = !ok;
        gData[cyc]    = (ok && !(lsuWin && w)) ? refMem[idx] : 32'd0;
        flushLog[cyc] = fl;
        rstLog[cyc]   = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            expResp(lat, cyc, ev, eLsu, eErr, eData);
            eIfuV = ev && !eLsu;  eLsuV = ev && eLsu;
            eIfuErr = eIfuV && eErr;  eLsuErr = eLsuV && eErr;
            eIfuData = eIfuV ? eData : 32'd0;  eLsuData = eLsuV ? eData : 32'd0;
            vectors++;
            if (ifuReady[i] !== ifuWin) begin miscompares++;
                $display("FAIL lat%0d cyc%0d ifu_req_ready: got %b want %b", lat, cyc, ifuReady[i], ifuWin); end
            vectors++;
            if (lsuReady[i] !== lsuWin) begin miscompares++;
                $display("FAIL lat%0d cyc%0d lsu_req_ready: got %b want %b", lat, cyc, lsuReady[i], lsuWin); end
            vectors++;
            if (memEn[i] !== expEn) begin miscompares++;
                $display("FAIL lat%0d cyc%0d mem_en: got %b want %b", lat, cyc, memEn[i], expEn); end
            if (r) begin
                vectors++;
                if ({memWen[i], memIdx[i], memWdata[i], memWmask[i]} !== 45'd0) begin miscompares++;
                    $display("FAIL lat%0d cyc%0d mem_port_in_reset: got wen %b idx %0d wdata %h wmask %b want all 0",
                             lat, cyc, memWen[i], memIdx[i], memWdata[i], memWmask[i]); end
            end else if (expEn) begin
                vectors++;
                if (memWen[i] !== (lsuWin && w) || memIdx[i] !== 8'(idx)) begin miscompares++;
                    $display("FAIL lat%0d cyc%0d mem_wen_idx: got %b/%0d want %b/%0d",
                             lat, cyc, memWen[i], memIdx[i], lsuWin && w, idx); end
                if (lsuWin && w) begin
                    vectors++;
                    if (memWdata[i] !== wd || memWmask[i] !== wm) begin miscompares++;
                        $display("FAIL lat%0d cyc%0d mem_wdata_wmask: got %h/%b want %h/%b",
                                 lat, cyc, memWdata[i], memWmask[i], wd, wm); end
                end
            end
            vectors++;
            if (ifuRespValid[i] !== eIfuV || ifuRespErr[i] !== eIfuErr || ifuRespData[i] !== eIfuData) begin
                miscompares++;
                $display("FAIL lat%0d cyc%0d ifu_resp: got v%b e%b d%h want v%b e%b d%h", lat, cyc,
                         ifuRespValid[i], ifuRespErr[i], ifuRespData[i], eIfuV, eIfuErr, eIfuData); end
            vectors++;
            if (lsuRespValid[i] !== eLsuV || lsuRespErr[i] !== eLsuErr || lsuRespData[i] !== eLsuData) begin
                miscompares++;
                $display("FAIL lat%0d cyc%0d lsu_resp: got v%b e%b d%h want v%b e%b d%h", lat, cyc,
                         lsuRespValid[i], lsuRespErr[i], lsuRespData[i], eLsuV, eLsuErr, eLsuData); end
            lastIfuReady[i] = ifuReady[i];   lastLsuReady[i] = lsuReady[i];
            lastMemEn[i] = memEn[i];         lastMemIdx[i] = memIdx[i];
            lastIfuRespValid[i] = ifuRespValid[i];  lastIfuRespData[i] = ifuRespData[i];
            lastLsuRespValid[i] = lsuRespValid[i];  lastLsuRespData[i] = lsuRespData[i];
            lastLsuRespErr[i] = lsuRespErr[i];
        end
        if (lsuWin && w && ok)
            for (int b = 0; b < 4; b++) if (wm[b]) refMem[idx][8*b +: 8] = wd[8*b +: 8];
        if (r || !iv || ifuWin) streak = 0;
        else if (lsuWin && streak < StreakMax) streak++;
        ifuGot = ifuWin; lsuGot = lsuWin;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, 0, '0, '0, 0, dummyI, dummyL);
    endtask

    task automatic test_reset();
        step(0, '0, 0, 0, '0, 0, '0, '0, 1, dummyI, dummyL);
        step(1, PcRst, 0, 1, PcRst + 32'd4, 0, '0, '0, 1, dummyI, dummyL);
        vectors++;
        if (lastIfuReady[0] !== 1'b0 || lastLsuReady[0] !== 1'b0) begin miscompares++;
            $display("FAIL reset_ready: got ifu %b lsu %b want 0 0", lastIfuReady[0], lastLsuReady[0]); end
        idle(1);
    endtask

    task automatic test_fetch();
        step(1, PcRst + 32'd8, 0, 0, '0, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastMemEn[0] !== 1'b1 || lastMemIdx[0] !== 8'd2) begin miscompares++;
            $display("FAIL fetch_idx: got en %b idx %0d want 1 2", lastMemEn[0], lastMemIdx[0]); end
        idle(1);
        vectors++;
        if (lastIfuRespValid[0] !== 1'b1 || lastIfuRespData[0] !== initWord[2]) begin miscompares++;
            $display("FAIL fetch_resp: got v%b d%h want v1 d%h", lastIfuRespValid[0], lastIfuRespData[0], initWord[2]); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 15; k++) begin
            step(1, PcRst + 32'(4 * $urandom_range(0, 255)), 0,
                 1, PcRst + 32'(4 * $urandom_range(0, 255)), 0, '0, '0, 0, dummyI, dummyL);
            vectors++;
            if (lastIfuReady[0] !== ((k % 5) == 4) || lastLsuReady[0] !== ((k % 5) != 4)) begin miscompares++;
                $display("FAIL streak_pattern k%0d: got ifu %b lsu %b want ifu %b",
                         k, lastIfuReady[0], lastLsuReady[0], (k % 5) == 4); end
        end
        idle(4);
    endtask

    task automatic test_flush();
        step(1, PcRst + 32'd40, 0, 0, '0, 0, '0, '0, 0, dummyI, dummyL);
        step(1, PcRst + 32'd200, 1, 1, PcRst + 32'd68, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastIfuRespValid[0] !== 1'b0) begin miscompares++;
            $display("FAIL flush_same_cycle: got ifu_resp_valid %b want 0", lastIfuRespValid[0]); end
        idle(1);
        vectors++;
        if (lastLsuRespValid[0] !== 1'b1 || lastLsuRespData[0] !== initWord[17]) begin miscompares++;
            $display("FAIL flush_lsu_lat1: got v%b d%h want v1 d%h", lastLsuRespValid[0], lastLsuRespData[0], initWord[17]); end
        idle(1);
        vectors++;
        if (lastIfuRespValid[1] !== 1'b0) begin miscompares++;
            $display("FAIL flush_killed_lat3: got ifu_resp_valid %b want 0", lastIfuRespValid[1]); end
        idle(1);
        vectors++;
        if (lastLsuRespValid[1] !== 1'b1 || lastLsuRespData[1] !== initWord[17]) begin miscompares++;
            $display("FAIL flush_lsu_lat3: got v%b d%h want v1 d%h", lastLsuRespValid[1], lastLsuRespData[1], initWord[17]); end
        idle(3);
    endtask

    task automatic test_range();
        step(0, '0, 0, 1, PcRst - 32'd4, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastMemEn[0] !== 1'b0) begin miscompares++;
            $display("FAIL range_low_en: got %b want 0", lastMemEn[0]); end
        step(0, '0, 0, 1, PcRst + 32'd1024, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastMemEn[0] !== 1'b0 || lastLsuRespErr[0] !== 1'b1 || lastLsuRespData[0] !== 32'd0) begin miscompares++;
            $display("FAIL range_high: got en %b err %b d%h want 0 1 0", lastMemEn[0], lastLsuRespErr[0], lastLsuRespData[0]); end
        idle(1);
        vectors++;
        if (lastLsuRespValid[0] !== 1'b1 || lastLsuRespErr[0] !== 1'b1) begin miscompares++;
            $display("FAIL range_high_resp: got v%b err %b want 1 1", lastLsuRespValid[0], lastLsuRespErr[0]); end
        step(1, PcRst + 32'd2048, 0, 0, '0, 0, '0, '0, 0, dummyI, dummyL);
        idle(4);
    endtask

    task automatic test_store_merge();
        logic [31:0] want;
        want = {initWord[5][31:16], 16'hBEEF};
        step(0, '0, 0, 1, PcRst + 32'd20, 1, 32'hDEAD_BEEF, 4'b0011, 0, dummyI, dummyL);
        step(0, '0, 0, 1, PcRst + 32'd20, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastLsuRespValid[0] !== 1'b1 || lastLsuRespData[0] !== 32'd0) begin miscompares++;
            $display("FAIL store_ack: got v%b d%h want v1 d0", lastLsuRespValid[0], lastLsuRespData[0]); end
        idle(1);
        vectors++;
        if (lastLsuRespData[0] !== want) begin miscompares++;
            $display("FAIL store_merge: got %h want %h", lastLsuRespData[0], want); end
        step(0, '0, 0, 1, PcRst + 32'd24, 1, 32'h1234_5678, 4'b0000, 0, dummyI, dummyL);
        idle(4);
    endtask

    task automatic test_reset_inflight();
        step(0, '0, 0, 1, PcRst + 32'd12, 0, '0, '0, 0, dummyI, dummyL);
        step(1, PcRst + 32'd16, 0, 0, '0, 0, '0, '0, 0, dummyI, dummyL);
        step(1, PcRst + 32'd16, 0, 1, PcRst + 32'd28, 0, '0, '0, 1, dummyI, dummyL);
        vectors++;
        if (lastIfuRespValid[0] !== 1'b0 || lastMemEn[0] !== 1'b0 || lastLsuReady[0] !== 1'b0) begin miscompares++;
            $display("FAIL reset_inflight: got resp %b en %b ready %b want 0 0 0",
                     lastIfuRespValid[0], lastMemEn[0], lastLsuReady[0]); end
        step(1, PcRst + 32'd16, 0, 1, PcRst + 32'd28, 0, '0, '0, 0, dummyI, dummyL);
        vectors++;
        if (lastLsuReady[0] !== 1'b1 || lastLsuRespValid[1] !== 1'b0) begin miscompares++;
            $display("FAIL reset_release: got ready %b lat3_resp %b want 1 0", lastLsuReady[0], lastLsuRespValid[1]); end
        idle(5);
    endtask

    task automatic test_random();
        bit pi, pl, w, fl, r, gi, gl;
        logic [31:0] ai, al, wd;
        logic [3:0] wm;
        pi = 0; pl = 0; w = 0; ai = '0; al = '0; wd = '0; wm = '0;
        for (int n = 0; n < 800; n++) begin
            fl = ($urandom_range(0, 99) < 8);
            r  = ($urandom_range(0, 99) < 1);
            if (!pi || fl) begin pi = ($urandom_range(0, 99) < 70); ai = randAddr(); end
            if (!pl) begin
                pl = ($urandom_range(0, 99) < 50); al = randAddr();
                w = 1'($urandom_range(0, 1)); wd = $urandom; wm = 4'($urandom);
            end
            step(pi, ai, fl, pl, al, w, wd, wm, r, gi, gl);
            if (gi) pi = 0;
            if (gl) pl = 0;
        end
        idle(4);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; streak = 0;
        for (int k = 0; k < int'(Words); k++) begin
            initWord[k] = $urandom;
            refMem[k] = initWord[k];
        end
        rst = 1; ifuReqValid = 0; ifuAddr = '0; ifuFlush = 0;
        lsuReqValid = 0; lsuAddr = '0; lsuWen = 0; lsuWdata = '0; lsuWmask = '0;
        loadMem = 1;
        @(posedge clk); #1;
        loadMem = 0;
        @(posedge clk); #1;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_flush();
        test_range();
        test_store_merge();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
